// File: rtl/mem_access_unit_pkg.sv
// Shared types for the memory-access stage: access widths, pipeline bundles,
// data-memory request/response and the FSM state encoding.
package mem_access_unit_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2,
        W_RSVD = 2'd3
    } acc_width_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        acc_width_e      width;
        logic [XLEN-1:0] wdata;
        logic            is_load;
        logic            is_store;
        logic            is_unsigned;
    } mem_ctrl_t;

    typedef struct packed {
        logic                  wenable;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       wdata;
    } rd_ctrl_t;

    typedef struct packed {
        logic            req;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [3:0]      be;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic            ack;
        logic [XLEN-1:0] rdata;
    } dmem_rsp_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-port data-memory bus with a req/ack handshake; the access unit is the
// master, the memory (or its model) the slave.
interface mem_access_unit_if #(
    parameter int XLEN = mem_access_unit_pkg::XLEN
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store lane enables/replication with fault
// detection, and load lane extraction with sign/zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      st_off_i,
    input  acc_width_e      st_width_i,
    input  logic [XLEN-1:0] st_wdata_i,
    output logic [3:0]      st_be_o,
    output logic [XLEN-1:0] st_wdata_o,
    output logic            st_fault_o,
    input  logic [1:0]      ld_off_i,
    input  acc_width_e      ld_width_i,
    input  logic            ld_unsigned_i,
    input  logic [XLEN-1:0] ld_rdata_i,
    output logic [XLEN-1:0] ld_value_o
);

    logic [XLEN-1:0] ld_shifted;

    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = st_wdata_i;
        st_fault_o = 1'b0;
        case (st_width_i)
            W_BYTE: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {(XLEN/8){st_wdata_i[7:0]}};
            end
            W_HALF: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {(XLEN/16){st_wdata_i[15:0]}};
                st_fault_o = st_off_i[0];
            end
            W_WORD: begin
                st_be_o    = 4'b1111;
                st_fault_o = |st_off_i;
            end
            default: st_fault_o = 1'b1;
        endcase
    end

    // Word loads are always aligned, so the shift only matters for byte/half.
    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_value_o = ld_shifted;
        case (ld_width_i)
            W_BYTE:  ld_value_o = {{(XLEN-8){~ld_unsigned_i & ld_shifted[7]}}, ld_shifted[7:0]};
            W_HALF:  ld_value_o = {{(XLEN-16){~ld_unsigned_i & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ld_value_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access stage: issues one data-memory access at a time over a req/ack
// bus, stalls upstream while it is outstanding, and registers the rd result.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [XLEN-1:0]       in_addr,
    input  logic [1:0]            in_width,
    input  logic [XLEN-1:0]       in_wdata,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic                  in_is_unsigned,
    input  logic                  in_rd_wenable,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [XLEN-1:0]       in_rd_wdata,
    input  logic                  flush,
    output logic                  stall_req,
    mem_access_unit_if.master     dmem,
    output logic                  out_valid,
    output logic                  out_rd_wenable,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic [XLEN-1:0]       out_rd_wdata,
    output logic                  misalign_fault
);

    mem_ctrl_t in_mem;
    rd_ctrl_t  in_rd;
    dmem_rsp_t rsp;
    logic      in_is_mem;

    state_e                state_q, state_d;
    dmem_req_t             dreq_q, dreq_d;
    logic [1:0]            ld_off_q, ld_off_d;
    acc_width_e            ld_width_q, ld_width_d;
    logic                  ld_uns_q, ld_uns_d;
    logic                  rd_we_q, rd_we_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  flushed_q, flushed_d;
    rd_ctrl_t              out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  fault_q, fault_d;
    logic                  stall;

    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic            st_fault;
    logic [XLEN-1:0] ld_value;

    assign in_mem = '{addr: in_addr, width: acc_width_e'(in_width), wdata: in_wdata,
                      is_load: in_is_load, is_store: in_is_store, is_unsigned: in_is_unsigned};
    assign in_rd  = '{wenable: in_rd_wenable, addr: in_rd_addr, wdata: in_rd_wdata};
    assign rsp    = '{ack: dmem.ack, rdata: dmem.rdata};
    assign in_is_mem = in_mem.is_load | in_mem.is_store;

    mem_lane_align #(.XLEN(XLEN)) u_lane (
        .st_off_i      (in_mem.addr[1:0]),
        .st_width_i    (in_mem.width),
        .st_wdata_i    (in_mem.wdata),
        .st_be_o       (st_be),
        .st_wdata_o    (st_wdata),
        .st_fault_o    (st_fault),
        .ld_off_i      (ld_off_q),
        .ld_width_i    (ld_width_q),
        .ld_unsigned_i (ld_uns_q),
        .ld_rdata_i    (rsp.rdata),
        .ld_value_o    (ld_value)
    );

    always_comb begin
        state_d     = state_q;
        dreq_d      = dreq_q;
        ld_off_d    = ld_off_q;
        ld_width_d  = ld_width_q;
        ld_uns_d    = ld_uns_q;
        rd_we_d     = rd_we_q;
        rd_addr_d   = rd_addr_q;
        flushed_d   = flushed_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        fault_d     = 1'b0;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    if (!in_is_mem) begin
                        out_valid_d = 1'b1;
                        out_d       = in_rd;
                    end else if (st_fault) begin
                        out_valid_d   = 1'b1;
                        fault_d       = 1'b1;
                        out_d.wenable = 1'b0;
                        out_d.addr    = in_rd.addr;
                    end else begin
                        stall      = 1'b1;
                        state_d    = S_WAIT;
                        ld_off_d   = in_mem.addr[1:0];
                        ld_width_d = in_mem.width;
                        ld_uns_d   = in_mem.is_unsigned;
                        rd_we_d    = in_rd.wenable;
                        rd_addr_d  = in_rd.addr;
                        flushed_d  = 1'b0;
                        // A load+store combination is treated as a store.
                        dreq_d = '{req: 1'b1, we: in_mem.is_store,
                                   addr: {in_mem.addr[XLEN-1:2], 2'b00},
                                   be: st_be, wdata: st_wdata};
                    end
                end
            end
            S_WAIT: begin
                stall = !rsp.ack;
                if (rsp.ack) begin
                    state_d   = S_IDLE;
                    dreq_d.req = 1'b0;
                    dreq_d.we  = 1'b0;
                    flushed_d = 1'b0;
                    if (!flushed_q && !flush) begin
                        out_valid_d = 1'b1;
                        out_d.addr  = rd_addr_q;
                        if (dreq_q.we) begin
                            out_d.wenable = 1'b0;
                        end else begin
                            out_d.wenable = rd_we_q;
                            out_d.wdata   = ld_value;
                        end
                    end
                end else if (flush) begin
                    // The bus request cannot be withdrawn; just discard its result.
                    flushed_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            dreq_q      <= '0;
            ld_off_q    <= 2'b00;
            ld_width_q  <= W_BYTE;
            ld_uns_q    <= 1'b0;
            rd_we_q     <= 1'b0;
            rd_addr_q   <= '0;
            flushed_q   <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            dreq_q      <= dreq_d;
            ld_off_q    <= ld_off_d;
            ld_width_q  <= ld_width_d;
            ld_uns_q    <= ld_uns_d;
            rd_we_q     <= rd_we_d;
            rd_addr_q   <= rd_addr_d;
            flushed_q   <= flushed_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            fault_q     <= fault_d;
        end
    end

    assign stall_req      = rst & stall;
    assign dmem.req       = dreq_q.req;
    assign dmem.we        = dreq_q.we;
    assign dmem.addr      = dreq_q.addr;
    assign dmem.be        = dreq_q.be;
    assign dmem.wdata     = dreq_q.wdata;
    assign out_valid      = out_valid_q;
    assign out_rd_wenable = out_q.wenable;
    assign out_rd_addr    = out_q.addr;
    assign out_rd_wdata   = out_q.wdata;
    assign misalign_fault = fault_q;

    a_no_ack_idle: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == S_IDLE && rsp.ack));
    a_no_ld_st: assert property (@(posedge clk) disable iff (!rst)
        !(in_valid && in_is_load && in_is_store));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: drives the execute bundle and plays the
// data memory by hand, checking every expected value written out below.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_is_load, in_is_store, in_is_unsigned, in_rd_wenable, flush;
    logic [31:0] in_addr, in_wdata, in_rd_wdata;
    logic [1:0]  in_width;
    logic [4:0]  in_rd_addr;
    logic        stall_req, out_valid, out_rd_wenable, misalign_fault;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_wdata;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.XLEN(32)) dmem ();

    mem_access_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_addr        (in_addr),
        .in_width       (in_width),
        .in_wdata       (in_wdata),
        .in_is_load     (in_is_load),
        .in_is_store    (in_is_store),
        .in_is_unsigned (in_is_unsigned),
        .in_rd_wenable  (in_rd_wenable),
        .in_rd_addr     (in_rd_addr),
        .in_rd_wdata    (in_rd_wdata),
        .flush          (flush),
        .stall_req      (stall_req),
        .dmem           (dmem),
        .out_valid      (out_valid),
        .out_rd_wenable (out_rd_wenable),
        .out_rd_addr    (out_rd_addr),
        .out_rd_wdata   (out_rd_wdata),
        .misalign_fault (misalign_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] addr, input logic [1:0] width,
                         input logic [31:0] wdata, input logic ld, input logic st,
                         input logic uns, input logic rdwe, input logic [4:0] rda,
                         input logic [31:0] rdw);
        in_valid       = v;
        in_addr        = addr;
        in_width       = width;
        in_wdata       = wdata;
        in_is_load     = ld;
        in_is_store    = st;
        in_is_unsigned = uns;
        in_rd_wenable  = rdwe;
        in_rd_addr     = rda;
        in_rd_wdata    = rdw;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    // Accept a memory op now, ack after wait_n idle request cycles; returns in the out_valid cycle.
    task automatic mem_op(input logic [31:0] addr, input logic [1:0] width, input logic uns,
                          input logic [4:0] rd, input logic [31:0] rdata, input int wait_n);
        drive(1'b1, addr, width, 32'h0, 1'b1, 1'b0, uns, 1'b1, rd, 32'h0);
        tick();
        idle();
        repeat (wait_n) tick();
        dmem.ack   = 1'b1;
        dmem.rdata = rdata;
        tick();
        dmem.ack   = 1'b0;
    endtask

    initial begin
        idle();
        flush      = 1'b0;
        dmem.ack   = 1'b0;
        dmem.rdata = 32'h0;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dmem_req", dmem.req, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_fault", misalign_fault, 0);
        chk("rst_rd_wdata", out_rd_wdata, 0);
        rst = 1'b1;
        tick();

        // Word load, ack three cycles after the request appears
        drive(1'b1, 32'h100, 2'd2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0);
        #1 chk("t1_stall_c0", stall_req, 1);
        tick();
        idle();
        chk("t1_req", dmem.req, 1);
        chk("t1_addr", dmem.addr, 32'h100);
        chk("t1_be", dmem.be, 4'hF);
        chk("t1_we", dmem.we, 0);
        chk("t1_stall_c1", stall_req, 1);
        tick();
        chk("t1_req_hold", dmem.req, 1);
        chk("t1_addr_hold", dmem.addr, 32'h100);
        chk("t1_stall_c2", stall_req, 1);
        tick();
        chk("t1_be_hold", dmem.be, 4'hF);
        chk("t1_stall_c3", stall_req, 1);
        tick();
        dmem.ack   = 1'b1;
        dmem.rdata = 32'hDEADBEEF;
        #1 chk("t1_stall_ack", stall_req, 0);
        chk("t1_req_at_ack", dmem.req, 1);
        chk("t1_no_early_valid", out_valid, 0);
        tick();
        dmem.ack = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_rd_wdata, 32'hDEADBEEF);
        chk("t1_rd_we", out_rd_wenable, 1);
        chk("t1_rd_addr", out_rd_addr, 5'd3);
        chk("t1_req_drop", dmem.req, 0);
        tick();
        chk("t1_pulse", out_valid, 0);

        // Sub-word loads with sign and zero extension
        mem_op(32'h203, 2'd0, 1'b0, 5'd10, 32'h80FF1234, 0);
        chk("t2_valid", out_valid, 1);
        chk("t2_byte_signed", out_rd_wdata, 32'hFFFFFF80);
        mem_op(32'h203, 2'd0, 1'b1, 5'd11, 32'h80FF1234, 0);
        chk("t2_byte_unsigned", out_rd_wdata, 32'h00000080);
        chk("t2_rd_addr", out_rd_addr, 5'd11);
        mem_op(32'h202, 2'd1, 1'b0, 5'd12, 32'h80FF1234, 1);
        chk("t2_half_signed", out_rd_wdata, 32'hFFFF80FF);
        chk("t2_half_we", out_rd_wenable, 1);

        // Misaligned half load and reserved width: no request, fault pulse
        drive(1'b1, 32'h101, 2'd1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 32'h0);
        #1 chk("t4_no_stall", stall_req, 0);
        tick();
        drive(1'b1, 32'h100, 2'd3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0);
        chk("t4_no_req", dmem.req, 0);
        chk("t4_valid", out_valid, 1);
        chk("t4_fault", misalign_fault, 1);
        chk("t4_rd_we", out_rd_wenable, 0);
        #1 chk("t4_rsvd_no_stall", stall_req, 0);
        tick();
        idle();
        chk("t4_rsvd_no_req", dmem.req, 0);
        chk("t4_rsvd_valid", out_valid, 1);
        chk("t4_rsvd_fault", misalign_fault, 1);
        chk("t4_rsvd_rd_we", out_rd_wenable, 0);
        tick();
        chk("t4_fault_pulse", misalign_fault, 0);
        chk("t4_valid_pulse", out_valid, 0);

        // Byte store at offset 1, then half store at offset 2
        drive(1'b1, 32'h301, 2'd0, 32'h000000AB, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0);
        #1 chk("t3_stall", stall_req, 1);
        tick();
        idle();
        chk("t3_we", dmem.we, 1);
        chk("t3_be", dmem.be, 4'b0010);
        chk("t3_wdata", dmem.wdata, 32'hABABABAB);
        chk("t3_addr", dmem.addr, 32'h300);
        dmem.ack = 1'b1;
        tick();
        dmem.ack = 1'b0;
        chk("t3_valid", out_valid, 1);
        chk("t3_rd_we", out_rd_wenable, 0);
        drive(1'b1, 32'h102, 2'd1, 32'h00001234, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0);
        tick();
        idle();
        chk("t3h_be", dmem.be, 4'b1100);
        chk("t3h_wdata", dmem.wdata, 32'h12341234);
        dmem.ack = 1'b1;
        tick();
        dmem.ack = 1'b0;
        chk("t3h_valid", out_valid, 1);

        // Flush while waiting: request held, result squashed
        drive(1'b1, 32'h400, 2'd2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0);
        tick();
        idle();
        flush = 1'b1;
        #1 chk("t5_stall_flush", stall_req, 1);
        chk("t5_req", dmem.req, 1);
        tick();
        flush = 1'b0;
        chk("t5_req_hold", dmem.req, 1);
        tick();
        dmem.ack   = 1'b1;
        dmem.rdata = 32'h12345678;
        #1 chk("t5_stall_ack", stall_req, 0);
        tick();
        dmem.ack = 1'b0;
        chk("t5_no_valid", out_valid, 0);
        chk("t5_req_drop", dmem.req, 0);
        drive(1'b1, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h00001234);
        #1 chk("t5_alu_no_stall", stall_req, 0);
        tick();
        idle();
        chk("t5_alu_valid", out_valid, 1);
        chk("t5_alu_data", out_rd_wdata, 32'h00001234);
        chk("t5_alu_rd", out_rd_addr, 5'd4);
        drive(1'b1, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, 32'h00000099);
        flush = 1'b1;
        tick();
        idle();
        flush = 1'b0;
        chk("t5_idle_flush_drop", out_valid, 0);

        // Asynchronous reset in the middle of a wait
        drive(1'b1, 32'h500, 2'd2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'h0);
        tick();
        idle();
        tick();
        chk("t6_req_before", dmem.req, 1);
        #2 rst = 1'b0;
        #1 chk("t6_req_async", dmem.req, 0);
        chk("t6_stall_async", stall_req, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 32'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h00000042);
        tick();
        idle();
        chk("t6_valid", out_valid, 1);
        chk("t6_rd", out_rd_addr, 5'd5);
        chk("t6_data", out_rd_wdata, 32'h00000042);
        chk("t6_we", out_rd_wenable, 1);
        tick();
        chk("t6_pulse", out_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
